trace_capture_ctrl: RTL and testbench



---
 rtl/trace_buf_pkg.sv | 18 +
 rtl/trace_wr_ptr.sv | 53 +++++
 rtl/trace_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trace_capture_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/trace_buf_pkg.sv
// Shared state and mode encodings for the trace-buffer capture path.
package trace_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  localparam logic LINEAR   = 1'b0;
  localparam logic CIRCULAR = 1'b1;

  function automatic logic is_capturing(input trace_state_e st);
    return (st == ARMED) || (st == POST);
  endfunction

endpackage

// File: rtl/trace_wr_ptr.sv
// Trace write pointer: modulo-depth counter, wrap flag and oldest-sample base address.
module trace_wr_ptr
  import trace_buf_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic          circ,
  output logic [AW-1:0] wr_ptr,
  output logic          wrapped,
  output logic [AW-1:0] base
);

  localparam logic [AW-1:0] PTR_MAX = '1;

  logic [AW-1:0] wr_ptr_r;
  logic          wrapped_r;

  // Pointer advance; a linear capture holds at the last address instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      wrapped_r <= 1'b0;
    end else if (clear) begin
      wr_ptr_r  <= '0;
      wrapped_r <= 1'b0;
    end else if (inc) begin
      if (wr_ptr_r == PTR_MAX) begin
        if (circ == CIRCULAR) begin
          wr_ptr_r  <= '0;
          wrapped_r <= 1'b1;
        end else begin
          wr_ptr_r  <= wr_ptr_r;
          wrapped_r <= wrapped_r;
        end
      end else begin
        wr_ptr_r  <= wr_ptr_r + AW'(1);
        wrapped_r <= wrapped_r;
      end
    end else begin
      wr_ptr_r  <= wr_ptr_r;
      wrapped_r <= wrapped_r;
    end
  end

  assign wr_ptr  = wr_ptr_r;
  assign wrapped = wrapped_r;
  assign base    = wrapped_r ? wr_ptr_r : '0;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Triggered trace capture controller: BRAM port A write sequencing and port B read addressing.
// Optional build macro TRACE_TIMESTAMP_EN places a free-running cycle count in the upper data bits.
module trace_capture_ctrl
  import trace_buf_pkg::*;
#(
  parameter int VECTOR_DATA_WIDTH    = 192,
  parameter int TRACE_BUF_DATA_WIDTH = 256,
  parameter int TRACE_BUF_ADDR_WIDTH = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic                            trigger,
  input  logic                            abort,
  input  logic                            circ_mode,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] post_count,
  input  logic                            rd_en_100ns,
  input  logic [VECTOR_DATA_WIDTH-1:0]    vctr_fifo_data_out,
  input  logic [31:0]                     trace_buf_bram_addr_slave,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addra,
  output logic [TRACE_BUF_DATA_WIDTH-1:0] trace_buf_bram_data_in,
  output logic                            trace_buf_we,
  output logic                            trace_buf_en,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addrb,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trig_addr,
  output logic                            wrapped,
  output logic                            busy,
  output logic                            done
);

  localparam int AW = TRACE_BUF_ADDR_WIDTH;
  localparam int VW = VECTOR_DATA_WIDTH;
  localparam int DW = TRACE_BUF_DATA_WIDTH;
  localparam logic [AW-1:0] PTR_MAX = '1;

  trace_state_e  state_r, nxt_s;
  logic          mode_r;
  logic [AW-1:0] post_lat_r, post_cnt_r, post_load_s;
  logic [AW-1:0] wr_ptr_s, base_s;
  logic          wrapped_s;
  logic          wr_acc_s, trig_take_s, lin_last_s, post_end_s;
  logic [DW-1:0] data_s;
  logic [AW-1:0] addra_r, addrb_r, trig_addr_r;
  logic [DW-1:0] data_r;
  logic          we_r, busy_r, done_r;
  logic          unused_s;

  assign unused_s = ^trace_buf_bram_addr_slave[31:AW];

  trace_wr_ptr #(.AW(AW)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear   (arm),
    .inc     (wr_acc_s),
    .circ    (mode_r),
    .wr_ptr  (wr_ptr_s),
    .wrapped (wrapped_s),
    .base    (base_s)
  );

`ifdef TRACE_TIMESTAMP_EN
  localparam int TSW = DW - VW;
  logic [TSW-1:0] ts_r;

  // Free-running cycle counter sampled alongside each vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_r <= '0;
    else     ts_r <= ts_r + TSW'(1);
  end
`endif

  // Write word assembly: sample in the low bits, optional timestamp above it
  always_comb begin
    data_s = '0;
    data_s[VW-1:0] = vctr_fifo_data_out;
`ifdef TRACE_TIMESTAMP_EN
    data_s[DW-1:VW] = ts_r;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= nxt_s;
  end

  // FSM next-state; arm has priority so a restart always wins
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (arm) nxt_s = ARMED;
        else     nxt_s = state_r;
      end
      ARMED: begin
        if (arm)                          nxt_s = ARMED;
        else if (abort || lin_last_s)     nxt_s = DONE;
        else if (trigger && post_end_s)   nxt_s = DONE;
        else if (trigger)                 nxt_s = POST;
        else                              nxt_s = ARMED;
      end
      POST: begin
        if (arm)                                        nxt_s = ARMED;
        else if (abort || lin_last_s)                   nxt_s = DONE;
        else if (wr_acc_s && post_cnt_r == AW'(1))      nxt_s = DONE;
        else                                            nxt_s = POST;
      end
      default: nxt_s = IDLE;
    endcase
  end

  // FSM decode: accepted samples, trigger capture, linear full and post-count load
  always_comb begin
    wr_acc_s    = rd_en_100ns && !arm && is_capturing(state_r);
    trig_take_s = trigger && !arm && (state_r == ARMED);
    lin_last_s  = wr_acc_s && (mode_r == LINEAR) && (wr_ptr_s == PTR_MAX);
    post_end_s  = (post_lat_r == '0) || (wr_acc_s && post_lat_r == AW'(1));
    if (wr_acc_s) post_load_s = post_lat_r - AW'(1);
    else          post_load_s = post_lat_r;
  end

  // Capture configuration, trigger address and post-trigger counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r      <= LINEAR;
      post_lat_r  <= '0;
      post_cnt_r  <= '0;
      trig_addr_r <= '0;
    end else if (arm) begin
      mode_r      <= circ_mode;
      post_lat_r  <= post_count;
      post_cnt_r  <= '0;
      trig_addr_r <= '0;
    end else if (trig_take_s) begin
      trig_addr_r <= wr_ptr_s;
      post_cnt_r  <= post_load_s;
    end else if (wr_acc_s && state_r == POST) begin
      post_cnt_r  <= post_cnt_r - AW'(1);
    end
  end

  // Registered BRAM ports and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      addra_r <= '0;
      data_r  <= '0;
      addrb_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      we_r    <= wr_acc_s;
      addrb_r <= base_s + trace_buf_bram_addr_slave[AW-1:0];
      busy_r  <= is_capturing(nxt_s);
      done_r  <= (nxt_s == DONE);
      if (wr_acc_s) begin
        addra_r <= wr_ptr_s;
        data_r  <= data_s;
      end
    end
  end

  assign trace_buf_bram_addra   = addra_r;
  assign trace_buf_bram_data_in = data_r;
  assign trace_buf_we           = we_r;
  assign trace_buf_en           = 1'b1;
  assign trace_buf_bram_addrb   = addrb_r;
  assign trig_addr              = trig_addr_r;
  assign wrapped                = wrapped_s;
  assign busy                   = busy_r;
  assign done                   = done_r;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl with a 16-entry buffer, 8-bit samples and 16-bit words.
module tb_trace_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, arm, trigger, abort, circ_mode, rd_en_100ns;
  logic [3:0]  post_count;
  logic [7:0]  vdata;
  logic [31:0] slave_off;
  logic [3:0]  addra, addrb, trig_addr;
  logic [15:0] data_in;
  logic        we, en, wrapped, busy, done;

  int checks = 0;
  int errors = 0;

  trace_capture_ctrl #(
    .VECTOR_DATA_WIDTH(8), .TRACE_BUF_DATA_WIDTH(16), .TRACE_BUF_ADDR_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .trigger(trigger), .abort(abort),
    .circ_mode(circ_mode), .post_count(post_count), .rd_en_100ns(rd_en_100ns),
    .vctr_fifo_data_out(vdata), .trace_buf_bram_addr_slave(slave_off),
    .trace_buf_bram_addra(addra), .trace_buf_bram_data_in(data_in),
    .trace_buf_we(we), .trace_buf_en(en), .trace_buf_bram_addrb(addrb),
    .trig_addr(trig_addr), .wrapped(wrapped), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic t, input logic ab, input logic r, input logic [7:0] d);
    arm = a; trigger = t; abort = ab; rd_en_100ns = r; vdata = d;
    @(posedge clk);
    #1;
    arm = 1'b0; trigger = 1'b0; abort = 1'b0; rd_en_100ns = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0; circ_mode = 1'b0;
    rd_en_100ns = 1'b0; post_count = 4'd0; vdata = 8'h00; slave_off = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addra", addra, 32'd0);
    chk("rst_addrb", addrb, 32'd0);
    chk("rst_data", data_in, 32'd0);
    chk("rst_we", we, 32'd0);
    chk("rst_trig", trig_addr, 32'd0);
    chk("rst_wrapped", wrapped, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_en", en, 32'd1);
    rst = 1'b0;

`ifdef TRACE_TIMESTAMP_EN
    circ_mode = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    chk("ts_first", data_in, 32'h0A5A);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
    chk("ts_second", data_in, 32'h0DC3);
`endif

    // Linear, post_count 3: pre-trigger 0..4, trigger sample at 5, post ends at 7
    circ_mode = 1'b0; post_count = 4'd3;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("lin_arm_busy", busy, 32'd1);
    chk("lin_arm_we", we, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i));
      chk("lin_pre_addra", addra, 32'(i));
      chk("lin_pre_data", data_in, 32'h00A0 + 32'(i));
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
    chk("lin_trig_addra", addra, 32'd5);
    chk("lin_trig_addr", trig_addr, 32'd5);
    chk("lin_trig_busy", busy, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hA6);
    chk("lin_post6", {done, we, addra}, {26'd0, 1'b0, 1'b1, 4'd6});
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hA7);
    chk("lin_post7", {busy, done, we, addra}, {26'd0, 1'b0, 1'b1, 1'b1, 4'd7});
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
      chk("lin_after_we", we, 32'd0);
    end
    chk("lin_addrb0", addrb, 32'd0);

    // Circular, post_count 4: 20 samples wrap, trigger at 4, finish with pointer at 8
    circ_mode = 1'b1; post_count = 4'd4;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'(i));
    chk("circ_wrapped", wrapped, 32'd1);
    chk("circ_last_pre", addra, 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("circ_trig_addr", trig_addr, 32'd4);
    chk("circ_trig_we", we, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h40 + 8'(i));
      chk("circ_post_addra", addra, 32'd4 + 32'(i));
      chk("circ_post_done", done, (i == 3) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("circ_addrb0", addrb, 32'd8);
    slave_off = 32'd15;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("circ_addrb15", addrb, 32'd7);
    slave_off = 32'd0;

    // Linear without trigger: stops after address 15
    circ_mode = 1'b0; post_count = 4'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("full_rearm_wrapped", wrapped, 32'd0);
    chk("full_rearm_trig", trig_addr, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h80 + 8'(i));
      chk("full_addra", {we, addra}, {27'd0, 1'b1, 4'(i)});
      chk("full_done", done, (i == 15) ? 32'd1 : 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    chk("full_17th_we", we, 32'd0);
    chk("full_wrapped", wrapped, 32'd0);

    // post_count 0: trigger without a sample ends on the next cycle
    post_count = 4'd0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("pc0_done", {busy, done, we}, {29'd0, 1'b0, 1'b1, 1'b0});
    chk("pc0_trig_addr", trig_addr, 32'd2);

    // Abort in POST with a same-cycle sample: sample lands, then done
    post_count = 4'd5;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h21);
    chk("abt_trig", {trig_addr, addra}, {24'd0, 4'd0, 4'd0});
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h23);
    chk("abt_write", {we, addra, data_in}, {11'd0, 1'b1, 4'd2, 16'h0023});
    chk("abt_done", {busy, done}, 32'd1);

    // Arm during capture discards the same-cycle sample; rst mid-POST clears everything
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h30);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h31);
    chk("rearm_discard_we", we, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h32);
    chk("pre_rst_we", {we, addra}, {27'd0, 1'b1, 4'd0});
    rd_en_100ns = 1'b1; vdata = 8'h33;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", we, 32'd0);
    chk("mid_rst_flags", {busy, done, wrapped}, 32'd0);
    chk("mid_rst_data", data_in, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; rd_en_100ns = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h44);
    chk("post_rst_addra", {we, addra, data_in}, {11'd0, 1'b1, 4'd0, 16'h0044});
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h45);
    chk("post_rst_addra1", addra, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
